// File: rtl/ccip_poll_scheduler.sv
// ---------------------------------------------------------------------------
// ccip_poll_scheduler
//
// Decides when a CCI-P c0 poll read may issue and which flow it targets.
// Flows that are disabled or beyond number_of_flows are skipped, a runtime
// divider inserts idle cycles between polls, and an outstanding counter caps
// the number of poll reads in flight. Dropping start drains in-flight reads
// before returning to IDLE.
//
// Parameters:
//   LMAX_NUM_OF_FLOWS  log2 of the flow table size
//   MAX_OUTSTANDING    maximum poll reads in flight (1..255)
//   CNT_W              width of the outstanding counter (derived)
//
// Ports:
//   clk               clock
//   reset             synchronous, active-high reset
//   start             enables scheduling; deassertion begins drain
//   number_of_flows   flows in use, ids 0..number_of_flows-1 (0 = none)
//   flow_enable_mask  per-flow enable; bits >= number_of_flows ignored
//   polling_rate      idle cycles inserted between polls
//   tx_alm_full       c0 TX almost-full, blocks issue
//   rsp_valid         one poll response returned this cycle
//   poll_valid        one-cycle poll request strobe
//   poll_flow_id      flow to poll (valid with poll_valid)
//   outstanding       poll reads in flight
//   idle              1 while the FSM is in IDLE
//   rsp_underflow     sticky: response seen while outstanding was 0
// ---------------------------------------------------------------------------
module ccip_poll_scheduler #(
   parameter int LMAX_NUM_OF_FLOWS = 1,
   parameter int MAX_OUTSTANDING   = 16,
   parameter int CNT_W             = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [LMAX_NUM_OF_FLOWS-1:0]      number_of_flows,
   input  logic [(2**LMAX_NUM_OF_FLOWS)-1:0] flow_enable_mask,
   input  logic [7:0]                        polling_rate,
   input  logic                              tx_alm_full,
   input  logic                              rsp_valid,
   output logic                              poll_valid,
   output logic [LMAX_NUM_OF_FLOWS-1:0]      poll_flow_id,
   output logic [CNT_W-1:0]                  outstanding,
   output logic                              idle,
   output logic                              rsp_underflow
);

   localparam int IDW       = LMAX_NUM_OF_FLOWS;
   localparam int NUM_SLOTS = 2**LMAX_NUM_OF_FLOWS;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_RATE,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t                 state_q, state_d;
   logic [IDW-1:0]         cursor_q, cursor_d;
   logic [7:0]             div_cnt_q, div_cnt_d;
   logic                   poll_valid_q, poll_valid_d;
   logic [IDW-1:0]         poll_flow_id_q, poll_flow_id_d;
   logic [CNT_W-1:0]       outstanding_q, outstanding_d;
   logic                   idle_q, idle_d;
   logic                   rsp_underflow_q, rsp_underflow_d;

   logic [NUM_SLOTS-1:0]   eligible;
   logic [IDW-1:0]         cursor_eff;
   logic [IDW-1:0]         scan_idx;
   logic                   sel_found;
   logic [IDW-1:0]         sel_id;
   logic [IDW:0]           sel_plus1;
   logic [IDW-1:0]         cursor_next;
   logic                   issue_stall;
   logic                   issue_fire;
   state_t                 stop_target;

   // Flow selection: rotate the eligible set so the cursor sits at bit 0 and
   // take the first set bit. Ineligible slots above number_of_flows are zero,
   // so wrapping over the whole table is the same as wrapping at
   // number_of_flows-1. A stale cursor past the flow count restarts at 0.
   always_comb begin
      eligible   = '0;
      cursor_eff = '0;
      scan_idx   = '0;
      sel_found  = 1'b0;
      sel_id     = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         eligible[i] = flow_enable_mask[i] && (IDW'(i) < number_of_flows);
      end
      cursor_eff = (cursor_q >= number_of_flows) ? '0 : cursor_q;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         scan_idx = cursor_eff + IDW'(k);
         if (!sel_found && eligible[scan_idx]) begin
            sel_found = 1'b1;
            sel_id    = scan_idx;
         end
      end
   end

   // Cursor after a poll points just past the selected flow, wrapping to 0
   // after the last flow in use. Computed one bit wider so selection+1 can
   // be compared against number_of_flows without overflow.
   always_comb begin
      sel_plus1   = {1'b0, sel_id} + (IDW + 1)'(1);
      cursor_next = (sel_plus1 == {1'b0, number_of_flows}) ? '0 : sel_plus1[IDW-1:0];
   end

   // A poll fires only from ISSUE with start still high, something eligible,
   // and neither TX back-pressure nor a full in-flight window.
   always_comb begin
      issue_stall = tx_alm_full || (outstanding_q == MAX_CNT);
      issue_fire  = (state_q == S_ISSUE) && start && sel_found && !issue_stall;
      stop_target = (outstanding_q != '0) ? S_DRAIN : S_IDLE;
   end

   // Scheduling FSM: IDLE waits for start, WAIT_RATE burns polling_rate+1
   // cycles, ISSUE emits at most one poll, DRAIN waits for in-flight reads
   // to come back after start drops.
   always_comb begin
      state_d        = state_q;
      cursor_d       = cursor_q;
      div_cnt_d      = div_cnt_q;
      poll_valid_d   = 1'b0;
      poll_flow_id_d = poll_flow_id_q;
      case (state_q)
         S_IDLE: begin
            cursor_d = '0;
            if (start) begin
               state_d   = S_WAIT_RATE;
               div_cnt_d = '0;
            end
         end
         S_WAIT_RATE: begin
            if (!start) begin
               state_d   = stop_target;
               div_cnt_d = '0;
            end else if (div_cnt_q == polling_rate) begin
               state_d   = S_ISSUE;
               div_cnt_d = '0;
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end
         S_ISSUE: begin
            if (!start) begin
               state_d = stop_target;
            end else if (!sel_found) begin
               state_d   = S_WAIT_RATE;
               div_cnt_d = '0;
            end else if (issue_fire) begin
               poll_valid_d   = 1'b1;
               poll_flow_id_d = sel_id;
               cursor_d       = cursor_next;
               state_d        = S_WAIT_RATE;
               div_cnt_d      = '0;
            end
         end
         S_DRAIN: begin
            cursor_d = '0;
            if (outstanding_q == '0) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d  = S_IDLE;
            cursor_d = '0;
         end
      endcase
      idle_d = (state_d == S_IDLE);
   end

   // In-flight accounting runs in every state. An issue and a response in the
   // same cycle cancel; a response with nothing in flight leaves the counter
   // at 0 and latches the sticky underflow flag.
   always_comb begin
      outstanding_d   = outstanding_q;
      rsp_underflow_d = rsp_underflow_q;
      if (rsp_valid && (outstanding_q == '0)) begin
         rsp_underflow_d = 1'b1;
      end
      if (issue_fire && !rsp_valid) begin
         outstanding_d = outstanding_q + CNT_W'(1);
      end else if (rsp_valid && !issue_fire && (outstanding_q != '0)) begin
         outstanding_d = outstanding_q - CNT_W'(1);
      end
   end

   // State and output registers; reset discards any in-flight accounting.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         cursor_q        <= '0;
         div_cnt_q       <= '0;
         poll_valid_q    <= 1'b0;
         poll_flow_id_q  <= '0;
         outstanding_q   <= '0;
         idle_q          <= 1'b1;
         rsp_underflow_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cursor_q        <= cursor_d;
         div_cnt_q       <= div_cnt_d;
         poll_valid_q    <= poll_valid_d;
         poll_flow_id_q  <= poll_flow_id_d;
         outstanding_q   <= outstanding_d;
         idle_q          <= idle_d;
         rsp_underflow_q <= rsp_underflow_d;
      end
   end

   assign poll_valid    = poll_valid_q;
   assign poll_flow_id  = poll_flow_id_q;
   assign outstanding   = outstanding_q;
   assign idle          = idle_q;
   assign rsp_underflow = rsp_underflow_q;

endmodule

// File: tb/tb_ccip_poll_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ccip_poll_scheduler
//
// Directed bench for ccip_poll_scheduler with an 8-entry flow table and a
// six-deep in-flight window. Inputs change 1 time unit after each rising
// edge and outputs are sampled at the same point, so every check sees the
// registered result of the preceding edge.
// ---------------------------------------------------------------------------
module tb_ccip_poll_scheduler;

   localparam int TB_LMAX  = 3;
   localparam int TB_MAX   = 6;
   localparam int TB_CNT_W = $clog2(TB_MAX + 1);

   logic                clk;
   logic                reset;
   logic                start;
   logic [TB_LMAX-1:0]  number_of_flows;
   logic [7:0]          flow_enable_mask;
   logic [7:0]          polling_rate;
   logic                tx_alm_full;
   logic                rsp_valid;
   logic                poll_valid;
   logic [TB_LMAX-1:0]  poll_flow_id;
   logic [TB_CNT_W-1:0] outstanding;
   logic                idle;
   logic                rsp_underflow;

   int assertCount = 0;
   int failCount   = 0;

   ccip_poll_scheduler #(
      .LMAX_NUM_OF_FLOWS(TB_LMAX),
      .MAX_OUTSTANDING  (TB_MAX)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .number_of_flows  (number_of_flows),
      .flow_enable_mask (flow_enable_mask),
      .polling_rate     (polling_rate),
      .tx_alm_full      (tx_alm_full),
      .rsp_valid        (rsp_valid),
      .poll_valid       (poll_valid),
      .poll_flow_id     (poll_flow_id),
      .outstanding      (outstanding),
      .idle             (idle),
      .rsp_underflow    (rsp_underflow)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts the check and reports a mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive every scheduler input at once.
   task automatic applyStimulus(input logic st, input logic [TB_LMAX-1:0] nof,
                                input logic [7:0] mask, input logic [7:0] rate,
                                input logic alm, input logic rsp);
      start            = st;
      number_of_flows  = nof;
      flow_enable_mask = mask;
      polling_rate     = rate;
      tx_alm_full      = alm;
      rsp_valid        = rsp;
   endtask

   // One-cycle response strobe.
   task automatic rspPulse();
      rsp_valid = 1'b1;
      step();
      rsp_valid = 1'b0;
   endtask

   // Expect poll_valid low for gap-1 edges, then a pulse carrying id.
   task automatic expectPoll(input string tag, input int id, input int gap);
      for (int i = 1; i < gap; i++) begin
         step();
         checkOutput({tag, " quiet"}, poll_valid, 0);
      end
      step();
      checkOutput({tag, " valid"}, poll_valid, 1);
      checkOutput({tag, " id"}, poll_flow_id, id);
   endtask

   // Count poll pulses over a fixed number of edges.
   task automatic countPolls(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (poll_valid) seen++;
      end
   endtask

   // Bounded wait for the next poll pulse; timing out counts as a failure.
   task automatic waitPoll(input string tag, input int maxCycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         step();
         if (poll_valid) seen = 1'b1;
      end
      checkOutput({tag, " arrived"}, int'(seen), 1);
   endtask

   initial begin
      int polls;

      reset = 1'b1;
      applyStimulus(1'b0, 3'd0, 8'h00, 8'd0, 1'b0, 1'b0);
      step();
      step();
      checkOutput("rst poll_valid", poll_valid, 0);
      checkOutput("rst poll_flow_id", poll_flow_id, 0);
      checkOutput("rst outstanding", outstanding, 0);
      checkOutput("rst idle", idle, 1);
      checkOutput("rst underflow", rsp_underflow, 0);
      reset = 1'b0;
      step();

      // Four flows, all enabled, no divider: round-robin every 2 cycles,
      // first pulse at the third edge counting the start-sampling edge as 1.
      $display("[TB] round-robin, polling_rate=0");
      applyStimulus(1'b1, 3'd4, 8'h0F, 8'd0, 1'b0, 1'b0);
      step();
      checkOutput("rr idle after start", idle, 0);
      checkOutput("rr no poll at start edge", poll_valid, 0);
      expectPoll("rr p0", 0, 2);
      expectPoll("rr p1", 1, 2);
      expectPoll("rr p2", 2, 2);
      expectPoll("rr p3", 3, 2);
      expectPoll("rr p4", 0, 2);
      step();
      checkOutput("rr outstanding", outstanding, 5);

      // Reset mid-stream with five reads in flight.
      $display("[TB] reset mid-stream");
      reset = 1'b1;
      start = 1'b0;
      step();
      checkOutput("mid rst poll_valid", poll_valid, 0);
      checkOutput("mid rst poll_flow_id", poll_flow_id, 0);
      checkOutput("mid rst outstanding", outstanding, 0);
      checkOutput("mid rst idle", idle, 1);
      checkOutput("mid rst underflow", rsp_underflow, 0);
      reset = 1'b0;
      step();
      checkOutput("post rst idle", idle, 1);

      // Response with nothing in flight.
      $display("[TB] response underflow");
      rspPulse();
      checkOutput("uf flag", rsp_underflow, 1);
      checkOutput("uf outstanding", outstanding, 0);
      step();
      step();
      checkOutput("uf flag sticky", rsp_underflow, 1);

      // Sparse mask with a divider of 3: ids 1,3 alternate every 5 cycles.
      $display("[TB] sparse mask, polling_rate=3");
      applyStimulus(1'b1, 3'd4, 8'b0000_1010, 8'd3, 1'b0, 1'b0);
      step();
      checkOutput("sp idle after start", idle, 0);
      expectPoll("sp p0", 1, 5);
      expectPoll("sp p1", 3, 5);
      expectPoll("sp p2", 1, 5);
      expectPoll("sp p3", 3, 5);
      checkOutput("sp outstanding", outstanding, 4);

      flow_enable_mask = 8'h00;
      countPolls(12, polls);
      checkOutput("empty mask polls", polls, 0);
      flow_enable_mask = 8'b0000_1010;
      waitPoll("sp resume", 20);
      checkOutput("sp resume id", poll_flow_id, 1);
      checkOutput("sp resume outstanding", outstanding, 5);
      flow_enable_mask = 8'h00;
      rspPulse();
      rspPulse();
      checkOutput("pre-drain outstanding", outstanding, 3);

      // Drop start with three reads in flight: drain, then IDLE one edge
      // after the counter reaches zero.
      $display("[TB] drain");
      start = 1'b0;
      step();
      checkOutput("drain idle low", idle, 0);
      checkOutput("drain no poll", poll_valid, 0);
      rspPulse();
      rspPulse();
      rspPulse();
      checkOutput("drain outstanding", outstanding, 0);
      checkOutput("drain idle still low", idle, 0);
      step();
      checkOutput("drain idle", idle, 1);

      // Restart: the cursor was at 2 before draining, so id 0 proves restart.
      $display("[TB] restart");
      applyStimulus(1'b1, 3'd4, 8'h0F, 8'd0, 1'b0, 1'b0);
      step();
      expectPoll("rs p0", 0, 2);
      expectPoll("rs p1", 1, 2);
      checkOutput("rs outstanding", outstanding, 2);

      // TX almost-full with cursor at 2; release together with a response.
      $display("[TB] tx_alm_full stall");
      tx_alm_full = 1'b1;
      countPolls(5, polls);
      checkOutput("alm polls", polls, 0);
      checkOutput("alm outstanding", outstanding, 2);
      tx_alm_full = 1'b0;
      rspPulse();
      checkOutput("alm release valid", poll_valid, 1);
      checkOutput("alm release id", poll_flow_id, 2);
      checkOutput("poll+rsp outstanding", outstanding, 2);

      // Fill the in-flight window and hold in ISSUE.
      $display("[TB] outstanding cap");
      expectPoll("cap p0", 3, 2);
      expectPoll("cap p1", 0, 2);
      expectPoll("cap p2", 1, 2);
      expectPoll("cap p3", 2, 2);
      checkOutput("cap full", outstanding, 6);
      countPolls(6, polls);
      checkOutput("cap held polls", polls, 0);
      checkOutput("cap held outstanding", outstanding, 6);
      rspPulse();
      checkOutput("cap rsp outstanding", outstanding, 5);
      checkOutput("cap rsp no poll", poll_valid, 0);
      step();
      checkOutput("cap refill valid", poll_valid, 1);
      checkOutput("cap refill id", poll_flow_id, 3);
      checkOutput("cap refill outstanding", outstanding, 6);
      checkOutput("uf flag end", rsp_underflow, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
